// File: rtl/binary_add_14_1.sv
// binary_add_14_1: 14-bit unsigned adder with a registered, wrapping sum.
// The combinational sum comes from an explicit ripple-carry chain of full
// adders. The carry out of the top bit is never formed, so the result is
// (A + B) mod 2^14. S loads when en is high and is cleared asynchronously by
// rst_n.
module binary_add_14_1 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [13:0] A,
    input  logic [13:0] B,
    output logic [13:0] S
);

    localparam int W = 14;

    // carry[i] is the carry into stage i; stage 0 has no carry in.
    logic [W-1:0] carry;
    logic [W-1:0] sum_d;
    logic [W-1:0] sum_q;

    assign carry[0] = 1'b0;

    // Ripple-carry chain: one full-add stage per bit.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_stage
            assign sum_d[gi] = A[gi] ^ B[gi] ^ carry[gi];
            // The top stage has no carry out, which gives the wrap-around.
            if (gi < W - 1) begin : g_carry
                assign carry[gi+1] = (A[gi] & B[gi]) |
                                     (A[gi] & carry[gi]) |
                                     (B[gi] & carry[gi]);
            end
        end
    endgenerate

    // Sum register: cleared asynchronously, loaded on enabled rising edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_d;
        end
    end

    assign S = sum_q;

endmodule

// File: tb/tb_binary_add_14_1.sv
// Testbench for binary_add_14_1. Stimulus is driven on falling edges and each
// expected S is pushed into a queue. A monitor pops one entry and compares it
// 1 time unit after every rising edge. Asynchronous-reset checks and
// between-edge checks are made directly by the stimulus process.
module tb_binary_add_14_1;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [13:0] A;
    logic [13:0] B;
    logic [13:0] S;

    logic [13:0] exp_q[$];
    int          checks;
    int          passes;

    binary_add_14_1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .A     (A),
        .B     (B),
        .S     (S)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [13:0] act,
                         input logic [13:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: S=%0d expected %0d (A=%0d B=%0d en=%0b rst_n=%0b)",
                     name, act, exp, A, B, en, rst_n);
        end
    endtask

    // Drive one operand pair on the falling edge and queue the S value
    // that must appear after the following rising edge.
    task automatic apply(input logic [13:0] a, input logic [13:0] b,
                         input logic e, input logic [13:0] exp);
        @(negedge clk);
        A = a;
        B = b;
        en = e;
        exp_q.push_back(exp);
        $display("txn A=%0d B=%0d en=%0b rst_n=%0b -> expect S=%0d",
                 a, b, e, rst_n, exp);
    endtask

    // Monitor: compare one queued expectation after each rising edge.
    initial begin
        logic [13:0] exp;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                check("sum", S, exp);
            end
        end
    end

    // Directed vectors: {A, B, expected S}
    logic [13:0] vec_a [6] = '{14'd0, 14'd5, 14'd8191, 14'd16383, 14'd16383, 14'd10000};
    logic [13:0] vec_b [6] = '{14'd0, 14'd7, 14'd8192, 14'd1,     14'd16383, 14'd10000};
    logic [13:0] vec_s [6] = '{14'd0, 14'd12, 14'd16383, 14'd0,   14'd16382, 14'd3616};

    initial begin
        logic [13:0] ra;
        logic [13:0] rb;
        logic [14:0] full;
        int          waits;
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        A      = 14'd100;
        B      = 14'd200;

        #1;
        check("reset_state", S, 14'd0);

        // Held in reset with the clock running and en high: S stays 0.
        for (int i = 0; i < 3; i++) apply(14'd100, 14'd200, 1'b1, 14'd0);
        // Release on a falling edge; the next rising edge loads 100+200.
        apply(14'd100, 14'd200, 1'b1, 14'd300);
        rst_n = 1'b1;

        // Basic and wrap-around sums.
        for (int i = 0; i < 6; i++) apply(vec_a[i], vec_b[i], 1'b1, vec_s[i]);

        // Enable hold, then resume.
        apply(14'd5, 14'd7, 1'b1, 14'd12);
        for (int i = 0; i < 3; i++) apply(14'd1, 14'd1, 1'b0, 14'd12);
        apply(14'd1, 14'd1, 1'b1, 14'd2);

        // Input changes between edges must not reach S.
        apply(14'd3, 14'd4, 1'b1, 14'd7);
        @(posedge clk);
        #2;
        A = 14'd9000;
        B = 14'd77;
        #1;
        check("between_edges", S, 14'd7);

        // Asynchronous reset from a steady S=300, asserted between edges.
        apply(14'd100, 14'd200, 1'b1, 14'd300);
        apply(14'd100, 14'd200, 1'b1, 14'd300);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", S, 14'd0);
        apply(14'd100, 14'd200, 1'b1, 14'd0);
        apply(14'd4000, 14'd5000, 1'b1, 14'd9000);
        rst_n = 1'b1;

        // Reduced back-to-back sweep: pseudo-random pairs, one per cycle.
        for (int i = 0; i < 2000; i++) begin
            ra   = 14'($urandom_range(0, 16383));
            rb   = 14'($urandom_range(0, 16383));
            full = {1'b0, ra} + {1'b0, rb};
            apply(ra, rb, 1'b1, full[13:0]);
        end

        // Drain the scoreboard within a bounded number of cycles.
        waits = 0;
        while (exp_q.size() > 0 && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        checks++;
        if (exp_q.size() == 0) begin
            passes++;
        end else begin
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/binary_add_14_1.md
BINARY_ADD_14_1 -- requirements
Module: binary_add_14_1

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 14 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 en  input  1  update enable; active-high.
REQ-005 A  input  14  addend, unsigned.
REQ-006 B  input  14  addend, unsigned.
REQ-007 S  output  14  registered sum, unsigned.
REQ-008 The block SHALL have no other ports; carry-out and overflow are not exported.

Function
REQ-009 The block SHALL compute (A + B) mod 2^14 combinationally from the current A and B inputs.
- The datapath SHALL be a ripple-carry chain of 14 one-bit full-add stages.
- Stage 0 carry-in SHALL be 0.
- Each stage i SHALL produce sum[i] = A[i] ^ B[i] ^ c[i].
- Each stage i SHALL produce c[i+1] = majority(A[i], B[i], c[i]).
REQ-010 Carry-out of bit 13 SHALL be discarded, so the result wraps around (e.g. 16383 + 1 -> 0).
REQ-011 S SHALL be a register loaded with the combinational sum on each rising clk edge when rst_n=1 and en=1.
REQ-012 Latency SHALL be one clock.
- A and B stable before rising edge k -> S equals their wrapped sum immediately after edge k.
REQ-013 When en=0 at a rising edge, S SHALL hold its previous value.
REQ-014 A and B SHALL NOT be registered.
- Only the value present at the sampling edge matters.
- Changes between edges SHALL NOT affect S.
REQ-015 S SHALL change only on a rising clk edge (with en=1) or on assertion of rst_n.
- S SHALL be glitch-free between edges.
REQ-016 Back-to-back operation SHALL be supported.
- A new A/B pair every cycle gives a new result every cycle.
- No handshake, no stall, no bubbles.

Reset
REQ-017 rst_n=0 SHALL force S to 14'd0 immediately, independent of clk.
REQ-018 While rst_n=0, S SHALL stay 0 regardless of en, A, B and clock edges.
REQ-019 Reset asserted mid-operation SHALL discard the pending result.
- After release, the first rising edge with en=1 SHALL load the current A+B.
REQ-020 Release of rst_n SHALL take effect such that the next rising edge after release behaves per REQ-011/REQ-013.

Verification
REQ-021 Reset check: rst_n=0, A=100, B=200, en=1, clock running -> S=0 throughout.
- Then rst_n=1 -> S=300 after the next rising edge.
REQ-022 Basic sums, en=1, stimulus applied at falling edge, checked 1 time unit after the next rising edge:
- A=0, B=0 -> S=0.
- A=5, B=7 -> S=12.
- A=8191, B=8192 -> S=16383.
REQ-023 Wrap-around checks:
- A=16383, B=1 -> S=0.
- A=16383, B=16383 -> S=16382.
- A=10000, B=10000 -> S=3616.
REQ-024 Enable hold: load S=12 (A=5, B=7), then en=0 with A=1, B=1 for 3 cycles -> S stays 12.
- Then en=1 -> S=2 after one edge.
REQ-025 Asynchronous reset: S=300 steady, pull rst_n low midway between edges -> S=0 before the next clk edge.
REQ-026 Exhaustive sweep: all 2^28 (A,B) pairs, one pair per cycle, en=1 -> every S equals (A+B) mod 16384 one cycle after application.
